score_disp: RTL and testbench
=============================

SCORE_DISP -- requirements
Module: score_disp

Interface
REQ-001 Parameter REFRESH_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz).
REQ-002 Parameter BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s).
REQ-003 clk  in  1  master clock, 50 MHz; the block SHALL use this one clock only.
REQ-004 clr  in  1  synchronous, active-high reset (clear and reset all).
REQ-005 num3_disp..num0_disp  in  4 each  current score BCD digits from game_cont, num3 most significant.
REQ-006 game_state  in  3  game_cont state; bits [1:0]: 00 welcome, 01 run, 11 jump, 10 over; bit 2 ignored.
REQ-007 an  out  4  active-low one-hot digit anodes, an[3] = leftmost digit.
REQ-008 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 dp  out  1  active-low decimal point.

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-011 an, seg, dp SHALL be registered and SHALL change together exactly one cycle after the digit index changes; an = ~(1 << index).
REQ-012 Source SHALL be the high-score register when game_state[1:0]==00; otherwise the live num3..num0 inputs.
REQ-013 Decoder: digits 0-9 SHALL map to standard patterns (0 = 1000000, 1 = 1111001, 8 = 0000000); values 10-15 SHALL display '-' (0111111).
REQ-014 Leading-zero blanking: digit 3 blank if 0; digit 2 blank if digits 3,2 both 0; digit 1 blank if digits 3..1 all 0; digit 0 never blank; blank = seg 1111111 with anode still driven.
REQ-015 dp SHALL be 0 only on digit 0 while the high score is shown; 1 otherwise.
REQ-016 High-score update SHALL occur in the single cycle where game_state[1:0] goes from non-10 to 10 (registered previous state).
REQ-017 At that edge, live score SHALL be compared digit-wise, most-significant first, as a 16-bit unsigned BCD value; the high score SHALL be replaced only if live is strictly greater.
REQ-018 Any live digit >9 at the update edge SHALL suppress the update.
REQ-019 Repeated 10 cycles without a new entry edge SHALL not re-update; a 10->00->10 sequence SHALL update again.
REQ-020 Divider parameter values below 2 SHALL be treated as 2.

Reset
REQ-021 While clr=1 at a clk edge: an=1111, seg=1111111, dp=1, refresh counter=0, digit index=0, blink counter=0, blink phase=visible, high score=0000, previous state=00.
REQ-022 clr asserted mid-slot SHALL abort the slot; first digit after release SHALL be index 0 after a full REFRESH_DIV period.
REQ-023 clr coincident with a game-over edge SHALL win; the high score SHALL remain 0000.

Configuration
REQ-024 Macro SCORE_BLINK_EN defined: in state 10 a blink counter of period BLINK_DIV SHALL toggle a phase bit; in the hidden phase an SHALL be 1111 while scanning continues.
REQ-025 Blink counter and phase SHALL reset to 0/visible on every entry to state 10 and remain held outside it.
REQ-026 Macro SCORE_BLINK_EN undefined: no blink logic; state 10 SHALL display steadily like state 01.

Structure
REQ-027 Package score_disp_pkg SHALL hold the game-state encodings (00/01/11/10), the 16-entry segment pattern table, SEG_BLANK, SEG_DASH and AN_OFF constants.
REQ-028 Sub-module bcd_to_seg7 (purely combinational, 4-bit in, 7-bit active-low out) SHALL be instantiated once on the selected digit.
REQ-029 Counters SHALL be sized with $clog2 of their parameter.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-030 Live 0042, state 01 -> an cycles 1110,1101,1011,0111 each 4 clks; seg '2','4', then blank, blank; dp=1 always.
REQ-031 Live 0150, state 01->10, then state 00 -> high score 0150; digit 0 shows '0' with dp=0, digit 3 blank.
REQ-032 High 0150, next game over with live 0099 -> high stays 0150; then live 1000 -> high 1000.
REQ-033 Live digit1=12 at state 10 edge -> digit 1 shows '-', high unchanged.
REQ-034 With SCORE_BLINK_EN, state held 10 for 64 clks -> an alternates 16 clks scanning / 16 clks 1111, starting visible; without macro -> scanning never gated.
REQ-035 clr pulsed mid-slot with high 0150 -> next cycle an=1111, seg=1111111; state 00 afterwards shows '0' on digit 0 only.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display: game-state encodings, the
// seven-segment pattern table and the fixed display patterns.
package score_disp_pkg;

    // Encodings of game_state[1:0] as produced by game_cont.
    typedef enum logic [1:0] {
        GS_WELCOME = 2'b00,
        GS_RUN     = 2'b01,
        GS_OVER    = 2'b10,
        GS_JUMP    = 2'b11
    } game_state_e;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // All anodes released (active-low).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Entry n holds the pattern for value n; codes 10-15 show a dash.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH,   // 15..12
        SEG_DASH,   SEG_DASH,                           // 11..10
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, // 9..6
        7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, // 5..2
        7'b1111001, 7'b1000000                          // 1..0
    };

    // Pattern lookup for one 4-bit digit value.
    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/score_disp_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
module bcd_to_seg7
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup; out-of-range codes come back as a dash from the table.
    always_comb begin
        seg_o = seg_lookup(bcd_i);
    end

endmodule

// File: rtl/score_disp.sv
// Four-digit multiplexed score display with a high-score register.
// Shows the high score on the welcome screen and the live score otherwise.
// Optional feature: define SCORE_BLINK_EN to blink the display while the
// game is over; without it the game-over screen is steady.
module score_disp
    import score_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] num3_disp,
    input  logic [3:0] num2_disp,
    input  logic [3:0] num1_disp,
    input  logic [3:0] num0_disp,
    input  logic [2:0] game_state,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Dividers shorter than two cycles are stretched to two.
    localparam int REF_EFF = (REFRESH_DIV < 2) ? 2 : REFRESH_DIV;
    localparam int BLK_EFF = (BLINK_DIV < 2) ? 2 : BLINK_DIV;
    localparam int RW      = $clog2(REF_EFF);
    localparam int BW      = $clog2(BLK_EFF);
    localparam logic [RW-1:0] REF_LAST = RW'(REF_EFF - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLK_EFF - 1);

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    prev_gs_q;
    logic [15:0]   high_q, high_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [1:0]    gs_s;
    logic          show_high_s;
    logic          over_entry_s;
    logic          live_valid_s;
    logic [15:0]   live_s;
    logic [15:0]   src_s;
    logic [3:0]    digit_s;
    logic          blank_s;
    logic          hidden_s;
    logic [6:0]    dec_seg_s;

    // Bit 2 of the game state carries nothing for the display.
    logic          gs_bit2_unused_s;
    assign gs_bit2_unused_s = game_state[2];

    assign gs_s         = game_state[1:0];
    assign show_high_s  = (gs_s == GS_WELCOME);
    assign over_entry_s = (gs_s == GS_OVER) && (prev_gs_q != GS_OVER);
    assign live_s       = {num3_disp, num2_disp, num1_disp, num0_disp};
    assign live_valid_s = (num3_disp <= 4'd9) && (num2_disp <= 4'd9) &&
                          (num1_disp <= 4'd9) && (num0_disp <= 4'd9);

    // Refresh divider and digit index; the index steps on each divider wrap.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end else begin
            ref_cnt_d = ref_cnt_q + RW'(1);
        end
    end

    // Register the refresh divider and digit index.
    always_ff @(posedge clk) begin
        if (clr) begin
            ref_cnt_q <= '0;
            idx_q     <= 2'd0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
        end
    end

    // High score is captured once per game-over entry when the live score is
    // valid BCD and strictly larger; with valid BCD a plain unsigned compare
    // is the same as a digit-wise compare from the most significant digit.
    always_comb begin
        high_d = high_q;
        if (over_entry_s && live_valid_s && (live_s > high_q)) begin
            high_d = live_s;
        end else begin
            high_d = high_q;
        end
    end

    // Register the high score and the previous game state; clear wins over
    // a coincident game-over entry.
    always_ff @(posedge clk) begin
        if (clr) begin
            high_q    <= 16'h0000;
            prev_gs_q <= GS_WELCOME;
        end else begin
            high_q    <= high_d;
            prev_gs_q <= gs_s;
        end
    end

`ifdef SCORE_BLINK_EN
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blk_phase_q, blk_phase_d;

    // Blink timer: restarts visible on each game-over entry, runs only while
    // the game is over and holds its value elsewhere.
    always_comb begin
        blk_cnt_d   = blk_cnt_q;
        blk_phase_d = blk_phase_q;
        if (over_entry_s) begin
            blk_cnt_d   = '0;
            blk_phase_d = 1'b0;
        end else if (gs_s == GS_OVER) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d   = '0;
                blk_phase_d = ~blk_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BW'(1);
            end
        end else begin
            blk_cnt_d   = blk_cnt_q;
            blk_phase_d = blk_phase_q;
        end
    end

    // Register the blink timer.
    always_ff @(posedge clk) begin
        if (clr) begin
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
        end
    end

    // On the entry edge the stored phase is stale, so never hide there.
    assign hidden_s = (gs_s == GS_OVER) && !over_entry_s && blk_phase_q;
`else
    // Blink sizing is kept elaborated so both builds share one parameter set.
    logic [BW-1:0] blk_last_unused_s;
    assign blk_last_unused_s = BLK_LAST;
    assign hidden_s          = 1'b0;
`endif

    assign src_s = show_high_s ? high_q : live_s;

    // Select the digit for the current slot and decide leading-zero blanking.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        case (idx_q)
            2'd3: begin
                digit_s = src_s[15:12];
                blank_s = (src_s[15:12] == 4'd0);
            end
            2'd2: begin
                digit_s = src_s[11:8];
                blank_s = (src_s[15:8] == 8'd0);
            end
            2'd1: begin
                digit_s = src_s[7:4];
                blank_s = (src_s[15:4] == 12'd0);
            end
            2'd0: begin
                digit_s = src_s[3:0];
                blank_s = 1'b0;
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit_s),
        .seg_o (dec_seg_s)
    );

    // Next display drive for the current slot.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (hidden_s) begin
            an_d = AN_OFF;
        end else begin
            an_d = ~(4'b0001 << idx_q);
        end
        if (blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg_s;
        end
        if (show_high_s && (idx_q == 2'd0)) begin
            dp_d = 1'b0;
        end else begin
            dp_d = 1'b1;
        end
    end

    // Display outputs are registered so an, seg and dp move together.
    always_ff @(posedge clk) begin
        if (clr) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_score_disp.sv
// Directed self-checking bench for score_disp with REFRESH_DIV=4, BLINK_DIV=16.
module tb_score_disp;

    localparam logic [6:0] S_B  = 7'b1111111;
    localparam logic [6:0] S_DH = 7'b0111111;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S9   = 7'b0010000;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] num3, num2, num1, num0;
    logic [2:0] gstate;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    score_disp #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk        (clk),
        .clr        (clr),
        .num3_disp  (num3),
        .num2_disp  (num2),
        .num1_disp  (num1),
        .num0_disp  (num0),
        .game_state (gstate),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #2;
    endtask

    task automatic set_live(input logic [15:0] v);
        {num3, num2, num1, num0} = v;
    endtask

    // Expected anode for the slot visible after edge number cyc since release.
    function automatic logic [3:0] exp_an(input int c);
        int idx;
        logic [3:0] one;
        idx = ((c - 1) / 4) % 4;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    function automatic int exp_idx(input int c);
        return ((c - 1) / 4) % 4;
    endfunction

    // Scan 16 cycles (a full rotation) checking an, seg and dp each cycle.
    task automatic scan_check(input string tag, input logic [3:0][6:0] eseg, input logic [3:0] edp);
        int i;
        for (int s = 0; s < 16; s++) begin
            tick(1);
            i = exp_idx(cyc);
            check_eq($sformatf("%s an c%0d", tag, cyc), {12'd0, an}, {12'd0, exp_an(cyc)});
            check_eq($sformatf("%s seg d%0d", tag, i), {9'd0, seg}, {9'd0, eseg[i]});
            check_eq($sformatf("%s dp d%0d", tag, i), {15'd0, dp}, {15'd0, edp[i]});
        end
    endtask

    initial begin
        logic hid;
        clr    = 1'b1;
        gstate = 3'b000;
        set_live(16'h0000);
        tick(3);
        check_eq("reset an", {12'd0, an}, 16'h000F);
        check_eq("reset seg", {9'd0, seg}, 16'h007F);
        check_eq("reset dp", {15'd0, dp}, 16'h0001);

        // Release: welcome screen shows high score 0000 as a lone '0' with dp.
        clr = 1'b0;
        cyc = 0;
        scan_check("hs0", {S_B, S_B, S_B, S0}, 4'b1110);

        // Live 0042 running; bit 2 of the state must be ignored.
        gstate = 3'b101;
        set_live(16'h0042);
        scan_check("live42", {S_B, S_B, S4, S2}, 4'b1111);

        // Game over with 0150 captures it; welcome shows 0150.
        gstate = 3'b001; set_live(16'h0150); tick(1);
        gstate = 3'b010; tick(2);
        gstate = 3'b000;
        scan_check("hs150", {S_B, S1, S5, S0}, 4'b1110);

        // Smaller score, then a larger one while still over: no update.
        gstate = 3'b001; set_live(16'h0099); tick(1);
        gstate = 3'b010; tick(1);
        set_live(16'h0500); tick(2);
        gstate = 3'b000;
        scan_check("hs_keep", {S_B, S1, S5, S0}, 4'b1110);

        // New game over entry with 1000 updates.
        gstate = 3'b001; set_live(16'h1000); tick(1);
        gstate = 3'b010; tick(1);
        gstate = 3'b000;
        scan_check("hs1000", {S1, S0, S0, S0}, 4'b1110);

        // Invalid digit: shows a dash and suppresses an otherwise larger update.
        gstate = 3'b001; set_live(16'h99C5);
        scan_check("dash", {S9, S9, S_DH, S5}, 4'b1111);
        gstate = 3'b010; tick(2);
        gstate = 3'b000;
        scan_check("hs_inv", {S1, S0, S0, S0}, 4'b1110);

        // Hold game over for 64+ cycles and check anode gating.
        gstate = 3'b001; set_live(16'h0042); tick(1);
        gstate = 3'b010;
        for (int k = 0; k <= 64; k++) begin
            tick(1);
`ifdef SCORE_BLINK_EN
            hid = ((k >= 17) && (k <= 32)) || ((k >= 49) && (k <= 64));
`else
            hid = 1'b0;
`endif
            check_eq($sformatf("blink an k%0d", k), {12'd0, an},
                     hid ? 16'h000F : {12'd0, exp_an(cyc)});
        end
        gstate = 3'b001; tick(1);

        // Clear mid-slot coinciding with a game-over entry: clear wins.
        set_live(16'h0150); tick(2);
        clr = 1'b1; gstate = 3'b010; tick(1);
        check_eq("clr an", {12'd0, an}, 16'h000F);
        check_eq("clr seg", {9'd0, seg}, 16'h007F);
        check_eq("clr dp", {15'd0, dp}, 16'h0001);
        clr = 1'b0; gstate = 3'b000; cyc = 0;
        scan_check("post_clr", {S_B, S_B, S_B, S0}, 4'b1110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
